// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the stopwatch time-count datapath: merges button edges
// and UART command bytes, arbitrates them, and runs the run/stop/clear FSM.
module stopwatch_ctrl #(
  parameter int         CLEAR_CYCLES = 2,
  parameter logic [7:0] CMD_RUN      = 8'h72,
  parameter logic [7:0] CMD_CLEAR    = 8'h63,
  parameter logic [7:0] CMD_MODE     = 8'h6D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       enable,
  output logic       clear,
  output logic       change,
  output logic       cmd_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_CYCLES);

  // Button edge detection and UART decode
  logic run_prev, clear_prev, mode_prev;
  logic uart_run, uart_clear, uart_mode, uart_bad;
  logic run_req_d, clear_req_d, mode_req_d;

  always_comb begin
    uart_run    = rx_valid && (rx_data == CMD_RUN);
    uart_clear  = rx_valid && (rx_data == CMD_CLEAR);
    uart_mode   = rx_valid && (rx_data == CMD_MODE);
    uart_bad    = rx_valid && !(uart_run || uart_clear || uart_mode);
    // Both sources OR together, so a coincident button and byte is one event.
    run_req_d   = (btn_run   && !run_prev)   || uart_run;
    clear_req_d = (btn_clear && !clear_prev) || uart_clear;
    mode_req_d  = (btn_mode  && !mode_prev)  || uart_mode;
  end

  // Previous levels reset high so a button held through reset is not an event.
  logic run_req_q, clear_req_q, mode_req_q, bad_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_prev    <= 1'b1;
      clear_prev  <= 1'b1;
      mode_prev   <= 1'b1;
      run_req_q   <= 1'b0;
      clear_req_q <= 1'b0;
      mode_req_q  <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      run_prev    <= btn_run;
      clear_prev  <= btn_clear;
      mode_prev   <= btn_mode;
      run_req_q   <= run_req_d;
      clear_req_q <= clear_req_d;
      mode_req_q  <= mode_req_d;
      bad_q       <= uart_bad;
    end
  end

  // Run/stop/clear FSM
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        // Run has priority; a simultaneous clear is dropped.
        if (run_req_q) begin
          state_d = ST_RUN;
        end else if (clear_req_q) begin
          state_d = ST_CLEAR;
          cnt_d   = CLEAR_LOAD;
        end
      end
      ST_RUN: begin
        if (run_req_q) state_d = ST_STOP;
      end
      ST_CLEAR: begin
        // Leaving at 1 keeps the 8-bit counter from ever wrapping.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_STOP;
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      cnt_q   <= 8'd0;
      enable  <= 1'b0;
      clear   <= 1'b0;
      change  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enable  <= (state_d == ST_RUN);
      clear   <= (state_d == ST_CLEAR);
      change  <= change ^ mode_req_q;
      cmd_err <= bad_q;
    end
  end

  assign state = state_q;

endmodule
